// File: rtl/riscv_ma_lsu_pkg.sv
// Shared definitions for the memory-access / load-store stage:
//   - funct3 load/store encodings as in the RISC-V ISA
//   - access-size codes (funct3[1:0])
//   - stage FSM state type
//   - legality check for funct3 encodings given the datapath width
package riscv_ma_lsu_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Access size codes taken from funct3[1:0]
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_t;

    // 111 is never a valid encoding; LD/SD and LWU need a 64-bit datapath.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_64);
        logic ok;
        case (f3)
            3'b111:         ok = 1'b0;
            F3_LD, F3_LWU:  ok = is_64;
            default:        ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/riscv_ld_align.sv
// Load data alignment: selects the addressed field out of a full-width memory
// word and sign- or zero-extends it to XLEN.
// Ports:
//   i_rdata  [XLEN]        raw memory read data
//   i_lane   [log2(XLEN/8)] byte lane of the access
//   i_funct3 [3]           size (bits 1:0) and unsigned flag (bit 2)
//   o_value  [XLEN]        extended load result
module riscv_ld_align
    import riscv_ma_lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANEW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  i_rdata,
    input  logic [LANEW-1:0] i_lane,
    input  logic [2:0]       i_funct3,
    output logic [XLEN-1:0]  o_value
);

    logic [XLEN-1:0] w_shift;
    logic            w_ext;
    int              w_width;

    assign w_shift = i_rdata >> {i_lane, 3'b000};

    // Field width and extension bit, then fill everything above the field.
    always_comb begin
        w_width = XLEN;
        w_ext   = 1'b0;
        case (i_funct3[1:0])
            SZ_B: begin
                w_width = 8;
                w_ext   = ~i_funct3[2] & w_shift[7];
            end
            SZ_H: begin
                w_width = 16;
                w_ext   = ~i_funct3[2] & w_shift[15];
            end
            SZ_W: begin
                w_width = 32;
                w_ext   = ~i_funct3[2] & w_shift[31];
            end
            default: begin
                w_width = XLEN;
                w_ext   = 1'b0;
            end
        endcase
        o_value = '0;
        for (int i = 0; i < XLEN; i++) begin
            o_value[i] = (i < w_width) ? w_shift[i] : w_ext;
        end
    end

endmodule

// File: rtl/riscv_ma_lsu.sv
// Memory-access stage between EX and WB with a req/ack data-memory handshake.
// Non-memory ops pass through in one cycle; loads and stores go IDLE->BUSY and
// complete on mem_ack; misaligned or unsupported accesses fault without a
// memory request.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready          EX handshake
//   rdi, resi, sdata           destination, ALU result/address, store data
//   memfetch, memstore, funct3 op kind and size/sign
//   mem_req/we/addr/wdata/wstrb/ack/rdata   data-memory port
//   out_valid, rd, res, misaligned          registered writeback
module riscv_ma_lsu
    import riscv_ma_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int NB   = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [REGW-1:0] rdi,
    input  logic [XLEN-1:0] resi,
    input  logic [XLEN-1:0] sdata,
    input  logic            memfetch,
    input  logic            memstore,
    input  logic [2:0]      funct3,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [NB-1:0]   mem_wstrb,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    output logic [REGW-1:0] rd,
    output logic [XLEN-1:0] res,
    output logic            misaligned
);

    localparam int LANEW = $clog2(NB);

    // Byte strobes covering szb bytes starting at lane.
    function automatic logic [NB-1:0] strb_f(input logic [LANEW-1:0] lane, input logic [3:0] szb);
        logic [NB-1:0] s;
        s = '0;
        for (int i = 0; i < NB; i++) begin
            s[i] = (i >= int'(lane)) && (i < int'(lane) + int'(szb));
        end
        return s;
    endfunction

    // Low szb bytes of d replicated across every lane.
    function automatic logic [XLEN-1:0] rep_f(input logic [XLEN-1:0] d, input logic [3:0] szb);
        logic [XLEN-1:0] r;
        logic [LANEW-1:0] src;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            src = LANEW'(i) & LANEW'(szb - 4'd1);
            r[8*i +: 8] = d[{src, 3'b000} +: 8];
        end
        return r;
    endfunction

    lsu_state_t       r_state, w_state_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_mis, w_mis_nxt;
    logic [REGW-1:0]  r_rd, w_rd_nxt;
    logic [XLEN-1:0]  r_res, w_res_nxt;
    logic             r_mem_req, w_mem_req_nxt;
    logic             r_mem_we, w_mem_we_nxt;
    logic [XLEN-1:0]  r_mem_addr, w_mem_addr_nxt;
    logic [XLEN-1:0]  r_mem_wdata, w_mem_wdata_nxt;
    logic [NB-1:0]    r_mem_wstrb, w_mem_wstrb_nxt;
    // Context of the outstanding access, needed to finish it on mem_ack.
    logic [REGW-1:0]  r_pend_rd, w_pend_rd_nxt;
    logic [2:0]       r_pend_f3, w_pend_f3_nxt;
    logic [LANEW-1:0] r_pend_lane, w_pend_lane_nxt;
    logic             r_pend_load, w_pend_load_nxt;

    logic [LANEW-1:0] w_lane;
    logic [3:0]       w_szb;
    logic             w_misal;
    logic [XLEN-1:0]  w_ld_val;

    assign w_lane  = resi[LANEW-1:0];
    assign w_szb   = 4'd1 << funct3[1:0];
    assign w_misal = !f3_legal(funct3, XLEN == 64) ||
                     ((4'(w_lane) & (w_szb - 4'd1)) != 4'd0);

    riscv_ld_align #(.XLEN(XLEN), .LANEW(LANEW)) u_ld_align (
        .i_rdata  (mem_rdata),
        .i_lane   (r_pend_lane),
        .i_funct3 (r_pend_f3),
        .o_value  (w_ld_val)
    );

    // Next-state and next-output decode; everything holds unless updated.
    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = 1'b0;
        w_mis_nxt       = 1'b0;
        w_rd_nxt        = r_rd;
        w_res_nxt       = r_res;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wstrb_nxt = r_mem_wstrb;
        w_pend_rd_nxt   = r_pend_rd;
        w_pend_f3_nxt   = r_pend_f3;
        w_pend_lane_nxt = r_pend_lane;
        w_pend_load_nxt = r_pend_load;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!memfetch && !memstore) begin
                        w_out_valid_nxt = 1'b1;
                        w_rd_nxt        = rdi;
                        w_res_nxt       = resi;
                    end else if (w_misal) begin
                        // Report the faulting address, no register write.
                        w_out_valid_nxt = 1'b1;
                        w_mis_nxt       = 1'b1;
                        w_rd_nxt        = '0;
                        w_res_nxt       = resi;
                    end else begin
                        w_state_nxt     = ST_BUSY;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = memstore;
                        w_mem_addr_nxt  = {resi[XLEN-1:LANEW], {LANEW{1'b0}}};
                        w_mem_wstrb_nxt = memstore ? strb_f(w_lane, w_szb) : '0;
                        w_mem_wdata_nxt = memstore ? rep_f(sdata, w_szb) : '0;
                        w_pend_rd_nxt   = rdi;
                        w_pend_f3_nxt   = funct3;
                        w_pend_lane_nxt = w_lane;
                        w_pend_load_nxt = memfetch;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    w_state_nxt     = ST_IDLE;
                    w_mem_req_nxt   = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    if (r_pend_load) begin
                        w_rd_nxt  = r_pend_rd;
                        w_res_nxt = w_ld_val;
                    end else begin
                        w_rd_nxt = '0;
                    end
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_mis       <= 1'b0;
            r_rd        <= '0;
            r_res       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_pend_rd   <= '0;
            r_pend_f3   <= 3'b000;
            r_pend_lane <= '0;
            r_pend_load <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_mis       <= w_mis_nxt;
            r_rd        <= w_rd_nxt;
            r_res       <= w_res_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wstrb <= w_mem_wstrb_nxt;
            r_pend_rd   <= w_pend_rd_nxt;
            r_pend_f3   <= w_pend_f3_nxt;
            r_pend_lane <= w_pend_lane_nxt;
            r_pend_load <= w_pend_load_nxt;
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign misaligned = r_mis;
    assign rd         = r_rd;
    assign res        = r_res;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;

endmodule

// File: tb/tb_riscv_ma_lsu.sv
// Scoreboard bench for riscv_ma_lsu: one XLEN=32 and one XLEN=64 instance.
module tb_riscv_ma_lsu;
    import riscv_ma_lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv32, iv64, ack32, ack64;
    logic [4:0]  rdi;
    logic [63:0] resi, sdata, rdata;
    logic        memfetch, memstore;
    logic [2:0]  f3;

    logic        rdy32, req32, we32, ov32, mis32;
    logic [31:0] addr32, wdata32, res32;
    logic [3:0]  wstrb32;
    logic [4:0]  rd32;
    logic        rdy64, req64, we64, ov64, mis64;
    logic [63:0] addr64, wdata64, res64;
    logic [7:0]  wstrb64;
    logic [4:0]  rd64;

    riscv_ma_lsu #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32), .rdi(rdi),
        .resi(resi[31:0]), .sdata(sdata[31:0]), .memfetch(memfetch), .memstore(memstore),
        .funct3(f3), .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
        .mem_wdata(wdata32), .mem_wstrb(wstrb32), .mem_ack(ack32), .mem_rdata(rdata[31:0]),
        .out_valid(ov32), .rd(rd32), .res(res32), .misaligned(mis32)
    );

    riscv_ma_lsu #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(rdy64), .rdi(rdi),
        .resi(resi), .sdata(sdata), .memfetch(memfetch), .memstore(memstore),
        .funct3(f3), .mem_req(req64), .mem_we(we64), .mem_addr(addr64),
        .mem_wdata(wdata64), .mem_wstrb(wstrb64), .mem_ack(ack64), .mem_rdata(rdata),
        .out_valid(ov64), .rd(rd64), .res(res64), .misaligned(mis64)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] res;
        logic        mis;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Selected-DUT views for the stimulus tasks
    logic        sel;
    logic        m_ready, m_req, m_we, m_ov;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_wstrb;
    assign m_ready = sel ? rdy64 : rdy32;
    assign m_req   = sel ? req64 : req32;
    assign m_we    = sel ? we64  : we32;
    assign m_ov    = sel ? ov64  : ov32;
    assign m_addr  = sel ? addr64  : {32'd0, addr32};
    assign m_wdata = sel ? wdata64 : {32'd0, wdata32};
    assign m_wstrb = sel ? wstrb64 : {4'd0, wstrb32};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor for the 32-bit instance
    always @(negedge clk) begin
        if (rst === 1'b1 && ov32 === 1'b1) begin
            if (q32.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wb32_unexpected: rd=%0d res=0x%0h with no expectation", rd32, res32);
            end else begin
                e32 = q32.pop_front();
                chk("wb32_rd",  {59'd0, rd32}, {59'd0, e32.rd});
                chk("wb32_res", {32'd0, res32}, e32.res);
                chk("wb32_mis", {63'd0, mis32}, {63'd0, e32.mis});
            end
        end
    end

    // Monitor for the 64-bit instance
    always @(negedge clk) begin
        if (rst === 1'b1 && ov64 === 1'b1) begin
            if (q64.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wb64_unexpected: rd=%0d res=0x%0h with no expectation", rd64, res64);
            end else begin
                e64 = q64.pop_front();
                chk("wb64_rd",  {59'd0, rd64}, {59'd0, e64.rd});
                chk("wb64_res", res64, e64.res);
                chk("wb64_mis", {63'd0, mis64}, {63'd0, e64.mis});
            end
        end
    end

    task automatic drive(input logic s, input logic [4:0] r, input logic [63:0] a,
                         input logic [63:0] sd, input logic ld, input logic st, input logic [2:0] f);
        @(negedge clk);
        sel = s;
        #0;
        chk("in_ready_idle", {63'd0, m_ready}, 64'd1);
        rdi = r; resi = a; sdata = sd; memfetch = ld; memstore = st; f3 = f;
        if (s) iv64 = 1'b1; else iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0; iv64 = 1'b0;
    endtask

    // Non-memory or faulting op: result one cycle after acceptance, no request.
    task automatic simple_op(input logic s, input logic [4:0] r, input logic [63:0] a,
                             input logic ld, input logic st, input logic [2:0] f, input exp_t e);
        if (s) q64.push_back(e); else q32.push_back(e);
        drive(s, r, a, 64'd0, ld, st, f);
        chk("simple_ov", {63'd0, m_ov}, 64'd1);
        chk("simple_no_req", {63'd0, m_req}, 64'd0);
    endtask

    task automatic mem_op(input logic s, input logic [4:0] r, input logic [63:0] a,
                          input logic [63:0] sd, input logic ld, input logic st, input logic [2:0] f,
                          input logic [63:0] x_addr, input logic [7:0] x_strb, input logic [63:0] x_wdata,
                          input logic [63:0] rdat, input int waits, input exp_t e);
        if (s) q64.push_back(e); else q32.push_back(e);
        drive(s, r, a, sd, ld, st, f);
        chk("busy_req", {63'd0, m_req}, 64'd1);
        chk("busy_not_ready", {63'd0, m_ready}, 64'd0);
        chk("mem_addr", m_addr, x_addr);
        chk("mem_we", {63'd0, m_we}, {63'd0, st});
        if (st) begin
            chk("mem_wstrb", {56'd0, m_wstrb}, {56'd0, x_strb});
            chk("mem_wdata", m_wdata, x_wdata);
        end
        for (int k = 0; k < waits; k++) begin
            @(negedge clk);
            chk("wait_req_held", {63'd0, m_req}, 64'd1);
            chk("wait_addr_held", m_addr, x_addr);
            chk("wait_not_ready", {63'd0, m_ready}, 64'd0);
        end
        rdata = rdat;
        if (s) ack64 = 1'b1; else ack32 = 1'b1;
        @(negedge clk);
        ack32 = 1'b0; ack64 = 1'b0;
        chk("ack_req_drop", {63'd0, m_req}, 64'd0);
        chk("ack_wb_valid", {63'd0, m_ov}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; iv32 = 1'b0; iv64 = 1'b0; ack32 = 1'b0; ack64 = 1'b0;
        rdi = 5'd0; resi = 64'd0; sdata = 64'd0; rdata = 64'd0;
        memfetch = 1'b0; memstore = 1'b0; f3 = 3'b000; sel = 1'b0;
        #12;
        chk("rst_rd", {59'd0, rd32}, 64'd0);
        chk("rst_res", {32'd0, res32}, 64'd0);
        chk("rst_ov", {63'd0, ov32}, 64'd0);
        chk("rst_req", {63'd0, req32}, 64'd0);
        chk("rst_wstrb", {60'd0, wstrb32}, 64'd0);
        chk("rst_ready", {63'd0, rdy32}, 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // XLEN=32
        simple_op(1'b0, 5'd5, 64'd42, 1'b0, 1'b0, 3'b000, '{5'd5, 64'd42, 1'b0});
        simple_op(1'b0, 5'd3, 64'd34, 1'b1, 1'b0, F3_LW, '{5'd0, 64'd34, 1'b1});
        mem_op(1'b0, 5'd7, 64'h101, 64'd0, 1'b1, 1'b0, F3_LB, 64'h100, 8'h00, 64'd0,
               64'h8000, 3, '{5'd7, 64'hFFFF_FF80, 1'b0});
        mem_op(1'b0, 5'd7, 64'h101, 64'd0, 1'b1, 1'b0, F3_LBU, 64'h100, 8'h00, 64'd0,
               64'h8000, 1, '{5'd7, 64'h80, 1'b0});
        mem_op(1'b0, 5'd4, 64'h102, 64'h1234_ABCD, 1'b0, 1'b1, F3_SH, 64'h100, 8'b0000_1100,
               64'hABCD_ABCD, 64'd0, 1, '{5'd0, 64'h80, 1'b0});
        mem_op(1'b0, 5'd8, 64'h202, 64'd0, 1'b1, 1'b0, F3_LH, 64'h200, 8'h00, 64'd0,
               64'h8765_4321, 0, '{5'd8, 64'hFFFF_8765, 1'b0});
        mem_op(1'b0, 5'd8, 64'h202, 64'd0, 1'b1, 1'b0, F3_LHU, 64'h200, 8'h00, 64'd0,
               64'h8765_4321, 0, '{5'd8, 64'h8765, 1'b0});
        mem_op(1'b0, 5'd2, 64'h3, 64'h55, 1'b0, 1'b1, F3_SB, 64'h0, 8'b0000_1000,
               64'h5555_5555, 64'd0, 2, '{5'd0, 64'h8765, 1'b0});
        simple_op(1'b0, 5'd6, 64'h8, 1'b1, 1'b0, F3_LD, '{5'd0, 64'h8, 1'b1});
        simple_op(1'b0, 5'd6, 64'h40, 1'b1, 1'b0, 3'b111, '{5'd0, 64'h40, 1'b1});
        simple_op(1'b0, 5'd6, 64'h1, 1'b1, 1'b0, F3_LH, '{5'd0, 64'h1, 1'b1});
        simple_op(1'b0, 5'd6, 64'h2, 1'b0, 1'b1, F3_SW, '{5'd0, 64'h2, 1'b1});
        mem_op(1'b0, 5'd9, 64'h10, 64'hDEAD_BEEF, 1'b0, 1'b1, F3_SW, 64'h10, 8'b0000_1111,
               64'hDEAD_BEEF, 64'd0, 0, '{5'd0, 64'h2, 1'b0});

        // XLEN=64
        mem_op(1'b1, 5'd10, 64'h8, 64'd0, 1'b1, 1'b0, F3_LD, 64'h8, 8'h00, 64'd0,
               64'h0123_4567_89AB_CDEF, 0, '{5'd10, 64'h0123_4567_89AB_CDEF, 1'b0});
        mem_op(1'b1, 5'd11, 64'h4, 64'd0, 1'b1, 1'b0, F3_LWU, 64'h0, 8'h00, 64'd0,
               64'h8000_0000_1234_5678, 1, '{5'd11, 64'h0000_0000_8000_0000, 1'b0});
        mem_op(1'b1, 5'd11, 64'h4, 64'd0, 1'b1, 1'b0, F3_LW, 64'h0, 8'h00, 64'd0,
               64'h8000_0000_1234_5678, 0, '{5'd11, 64'hFFFF_FFFF_8000_0000, 1'b0});
        mem_op(1'b1, 5'd12, 64'h16, 64'hABCD, 1'b0, 1'b1, F3_SH, 64'h10, 8'b1100_0000,
               64'hABCD_ABCD_ABCD_ABCD, 64'd0, 0, '{5'd0, 64'hFFFF_FFFF_8000_0000, 1'b0});
        simple_op(1'b1, 5'd1, 64'hFFFF_0000_0000_0001, 1'b0, 1'b0, 3'b000,
                  '{5'd1, 64'hFFFF_0000_0000_0001, 1'b0});
        simple_op(1'b1, 5'd1, 64'h4, 1'b1, 1'b0, F3_LD, '{5'd0, 64'h4, 1'b1});

        // Reset in the middle of a 32-bit load
        drive(1'b0, 5'd13, 64'h20, 64'd0, 1'b1, 1'b0, F3_LW);
        chk("pre_rst_req", {63'd0, req32}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_busy_req", {63'd0, req32}, 64'd0);
        chk("rst_busy_rd", {59'd0, rd32}, 64'd0);
        chk("rst_busy_res", {32'd0, res32}, 64'd0);
        chk("rst_busy_ready", {63'd0, rdy32}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        // Late ack while IDLE must be ignored; a new op is accepted normally.
        ack32 = 1'b1;
        rdata = 64'hFFFF_FFFF;
        simple_op(1'b0, 5'd9, 64'h77, 1'b0, 1'b0, 3'b000, '{5'd9, 64'h77, 1'b0});
        @(negedge clk);
        ack32 = 1'b0;
        chk("late_ack_no_req", {63'd0, req32}, 64'd0);
        repeat (3) @(negedge clk);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
